// File: rtl/pcie_ss_hdr_pkg.sv
// Minimal PCIe subsystem header package: bus widths, power-user header
// layout and the request-type decode used by the TX A/B arbiter.
package pcie_ss_hdr_pkg;

  localparam int TDATA_W = 512;
  localparam int TKEEP_W = TDATA_W / 8;
  localparam int TUSER_W = 10;

  localparam logic [7:0] FMT_MWR32 = 8'h40;
  localparam logic [7:0] FMT_MWR64 = 8'h60;
  localparam logic [7:0] FMT_CPL   = 8'h0A;  // completion without data

  // Power-user header, carried in the low 256 bits of the SOP beat.
  typedef struct packed {
    logic [212:0] rsvd;
    logic         vf_active;
    logic [10:0]  vf_num;
    logic [2:0]   pf_num;
    logic [9:0]   tag;
    logic [9:0]   length;
    logic [7:0]   fmt_type;
  } pu_hdr_t;

  function automatic logic func_is_mwr_req(input logic [7:0] fmt_type);
    return (fmt_type == FMT_MWR32) || (fmt_type == FMT_MWR64);
  endfunction

endpackage

// File: rtl/pg_tx_ab_arb_pkg.sv
// Types and helpers for the port-gasket TX A/B arbiter.
// Optional statistics (macro PG_TX_AB_ARB_STATS_EN) add the counter indices.
package pg_tx_ab_arb_pkg;
  import pcie_ss_hdr_pkg::*;

  typedef enum logic [1:0] {
    IDLE,
    A_PKT,
    B_PKT
  } arb_state_e;

  // Everything needed to rebuild a local write-commit completion.
  typedef struct packed {
    logic [9:0]  tag;
    logic [2:0]  pf_num;
    logic [10:0] vf_num;
    logic        vf_active;
  } commit_t;

`ifdef PG_TX_AB_ARB_STATS_EN
  localparam int STATS_A_PKTS  = 0;
  localparam int STATS_B_PKTS  = 1;
  localparam int STATS_COMMITS = 2;
  localparam int STATS_STALLS  = 3;
`endif

  function automatic commit_t hdr_to_commit(input pu_hdr_t h);
    commit_t c;
    c.tag       = h.tag;
    c.pf_num    = h.pf_num;
    c.vf_num    = h.vf_num;
    c.vf_active = h.vf_active;
    return c;
  endfunction

  // Data-less completion header returned to the AFU as the write commit.
  function automatic pu_hdr_t build_commit_hdr(input commit_t c);
    pu_hdr_t h;
    h           = '0;
    h.fmt_type  = FMT_CPL;
    h.length    = '0;
    h.tag       = c.tag;
    h.pf_num    = c.pf_num;
    h.vf_num    = c.vf_num;
    h.vf_active = c.vf_active;
    return h;
  endfunction

endpackage

// File: rtl/pcie_ss_axis_if.sv
// AXI-Stream bundle used between the AFU, the arbiter and the FIM.
interface pcie_ss_axis_if
  import pcie_ss_hdr_pkg::*;
();
  logic               tvalid;
  logic               tready;
  logic [TDATA_W-1:0] tdata;
  logic [TKEEP_W-1:0] tkeep;
  logic               tlast;
  logic [TUSER_W-1:0] tuser_vendor;

  modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
  modport sink   (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
endinterface

// File: rtl/pg_tx_ab_commit_fifo.sv
// Synchronous FIFO of pending write commits; flushed by softreset.
module pg_tx_ab_commit_fifo
  import pg_tx_ab_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    softreset,
  input  logic    push,
  input  commit_t push_data,
  input  logic    pop,
  output commit_t pop_data,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  commit_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  // Storage write.
  // NOTE: the storage array has no reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; push and pop together leave occupancy unchanged.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (softreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/pg_tx_ab_arb.sv
// Port-gasket TX A/B merge: packet-atomic round-robin onto fim_tx_if, plus
// local write commits (one data-less Cpl per TX A MWr) on afu_rx_b_if.
// Optional: define PG_TX_AB_ARB_STATS_EN for saturating counters on stats_o.
module pg_tx_ab_arb
  import pcie_ss_hdr_pkg::*;
  import pg_tx_ab_arb_pkg::*;
#(
  parameter int COMMIT_FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           softreset,
  pcie_ss_axis_if.sink   afu_tx_a_if,
  pcie_ss_axis_if.sink   afu_tx_b_if,
  pcie_ss_axis_if.source fim_tx_if,
  pcie_ss_axis_if.source afu_rx_b_if
`ifdef PG_TX_AB_ARB_STATS_EN
  ,
  output logic [127:0]   stats_o
`endif
);
  arb_state_e state, state_nxt;
  logic       prio_a;
  logic       grant_a, grant_b, hs_a, hs_b;
  logic       in_idle, a_live_mwr, a_elig, b_elig;
  logic       info_mwr_q;
  commit_t    a_live, info_q, push_data, pop_data;
  logic       push, pop, fifo_full, fifo_empty;

  assign in_idle    = (state == IDLE);
  assign a_live     = hdr_to_commit(pu_hdr_t'(afu_tx_a_if.tdata[255:0]));
  assign a_live_mwr = func_is_mwr_req(afu_tx_a_if.tdata[7:0]);
  // A write may only start when its commit is guaranteed a FIFO slot.
  assign a_elig     = afu_tx_a_if.tvalid && !(a_live_mwr && fifo_full);
  assign b_elig     = afu_tx_b_if.tvalid;
  assign hs_a       = grant_a && afu_tx_a_if.tvalid && fim_tx_if.tready;
  assign hs_b       = grant_b && afu_tx_b_if.tvalid && fim_tx_if.tready;

  // State register, cleared by softreset (abandons any packet in flight).
  always_ff @(posedge clk) begin
    if (softreset) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next state: leave IDLE on a multi-beat SOP, return on the owner's tlast.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs_a && !afu_tx_a_if.tlast)      state_nxt = A_PKT;
        else if (hs_b && !afu_tx_b_if.tlast) state_nxt = B_PKT;
      end
      A_PKT:   if (hs_a && afu_tx_a_if.tlast) state_nxt = IDLE;
      B_PKT:   if (hs_b && afu_tx_b_if.tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant decode and zero-latency data mux toward the FIM.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!softreset) begin
      case (state)
        IDLE: begin
          if (a_elig && b_elig) begin
            grant_a = prio_a;
            grant_b = !prio_a;
          end else begin
            grant_a = a_elig;
            grant_b = b_elig;
          end
        end
        A_PKT:   grant_a = 1'b1;
        B_PKT:   grant_b = 1'b1;
        default: ;
      endcase
    end
    fim_tx_if.tvalid       = 1'b0;
    fim_tx_if.tdata        = '0;
    fim_tx_if.tkeep        = '0;
    fim_tx_if.tlast        = 1'b0;
    fim_tx_if.tuser_vendor = '0;
    if (grant_a) begin
      fim_tx_if.tvalid       = afu_tx_a_if.tvalid;
      fim_tx_if.tdata        = afu_tx_a_if.tdata;
      fim_tx_if.tkeep        = afu_tx_a_if.tkeep;
      fim_tx_if.tlast        = afu_tx_a_if.tlast;
      fim_tx_if.tuser_vendor = afu_tx_a_if.tuser_vendor;
    end else if (grant_b) begin
      fim_tx_if.tvalid       = afu_tx_b_if.tvalid;
      fim_tx_if.tdata        = afu_tx_b_if.tdata;
      fim_tx_if.tkeep        = afu_tx_b_if.tkeep;
      fim_tx_if.tlast        = afu_tx_b_if.tlast;
      fim_tx_if.tuser_vendor = afu_tx_b_if.tuser_vendor;
    end
    afu_tx_a_if.tready = grant_a && fim_tx_if.tready;
    afu_tx_b_if.tready = grant_b && fim_tx_if.tready;
  end

  // Round-robin priority and A packet info, both updated on SOP handshakes.
  always_ff @(posedge clk) begin
    if (softreset) begin
      prio_a     <= 1'b1;
      info_q     <= '0;
      info_mwr_q <= 1'b0;
    end else if (in_idle) begin
      if (hs_a || hs_b) prio_a <= !hs_a;
      if (hs_a) begin
        info_q     <= a_live;
        info_mwr_q <= a_live_mwr;
      end
    end
  end

  // Commit on the write's tlast handshake; a single-beat write uses live fields.
  assign push      = hs_a && afu_tx_a_if.tlast && (in_idle ? a_live_mwr : info_mwr_q);
  assign push_data = in_idle ? a_live : info_q;
  assign pop       = !fifo_empty && !softreset && afu_rx_b_if.tready;

  pg_tx_ab_commit_fifo #(
    .DEPTH (COMMIT_FIFO_DEPTH)
  ) u_commit_fifo (
    .clk       (clk),
    .softreset (softreset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Commit beat: one-beat Cpl header in the low 32 bytes.
  always_comb begin
    afu_rx_b_if.tvalid       = !fifo_empty && !softreset;
    afu_rx_b_if.tdata        = {{(TDATA_W-256){1'b0}}, build_commit_hdr(pop_data)};
    afu_rx_b_if.tkeep        = {{(TKEEP_W-32){1'b0}}, {32{1'b1}}};
    afu_rx_b_if.tlast        = 1'b1;
    afu_rx_b_if.tuser_vendor = '0;
  end

`ifdef PG_TX_AB_ARB_STATS_EN
  logic [31:0] stats_q [4];
  logic [3:0]  stats_ev;

  // Counter increment events.
  always_comb begin
    stats_ev                = '0;
    stats_ev[STATS_A_PKTS]  = hs_a && afu_tx_a_if.tlast;
    stats_ev[STATS_B_PKTS]  = hs_b && afu_tx_b_if.tlast;
    stats_ev[STATS_COMMITS] = pop;
    stats_ev[STATS_STALLS]  = !softreset && in_idle && afu_tx_a_if.tvalid &&
                              a_live_mwr && fifo_full;
  end

  // Saturating counters.
  always_ff @(posedge clk) begin
    if (softreset) begin
      for (int i = 0; i < 4; i++) stats_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (stats_ev[i] && (stats_q[i] != '1)) stats_q[i] <= stats_q[i] + 32'd1;
    end
  end

  assign stats_o = {stats_q[3], stats_q[2], stats_q[1], stats_q[0]};
`endif

endmodule

// File: tb/tb_pg_tx_ab_arb.sv
// Directed bench for pg_tx_ab_arb: arbitration order, packet atomicity,
// write-commit generation, FIFO back-pressure and mid-packet softreset.
module tb_pg_tx_ab_arb;
  import pcie_ss_hdr_pkg::*;

  localparam logic [7:0] T_MWR   = 8'h40;
  localparam logic [7:0] T_MWR64 = 8'h60;
  localparam logic [7:0] T_MRD   = 8'h20;
  localparam logic [7:0] T_MSG   = 8'h30;
  localparam logic [7:0] T_CPL   = 8'h0A;
  localparam logic [511:0] NONE  = '0;

  logic clk = 1'b0;
  logic softreset;
  int   total = 0;
  int   bad   = 0;

  logic n_rst, n_fim_rdy, n_rxb_rdy;

  pcie_ss_axis_if a_if ();
  pcie_ss_axis_if b_if ();
  pcie_ss_axis_if fim_if ();
  pcie_ss_axis_if rxb_if ();

`ifdef PG_TX_AB_ARB_STATS_EN
  logic [127:0] stats;
`endif

  pg_tx_ab_arb #(.COMMIT_FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .softreset   (softreset),
    .afu_tx_a_if (a_if),
    .afu_tx_b_if (b_if),
    .fim_tx_if   (fim_if),
    .afu_rx_b_if (rxb_if)
`ifdef PG_TX_AB_ARB_STATS_EN
    ,
    .stats_o     (stats)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] sop(input logic [7:0] fmt, input logic [9:0] tag,
                                        input logic [2:0] pf, input logic [10:0] vf,
                                        input logic vfa);
    pu_hdr_t h;
    h           = '0;
    h.fmt_type  = fmt;
    h.length    = 10'd4;
    h.tag       = tag;
    h.pf_num    = pf;
    h.vf_num    = vf;
    h.vf_active = vfa;
    return {256'hCAFE_F00D, h};
  endfunction

  function automatic logic [511:0] pay(input int i);
    logic [31:0] w;
    w = 32'hD000_0000 + 32'(i);
    return {16{w}};
  endfunction

  function automatic logic [511:0] exp_cpl(input logic [9:0] tag, input logic [2:0] pf,
                                            input logic [10:0] vf, input logic vfa);
    pu_hdr_t h;
    h           = '0;
    h.fmt_type  = T_CPL;
    h.tag       = tag;
    h.pf_num    = pf;
    h.vf_num    = vf;
    h.vf_active = vfa;
    return {256'b0, h};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge, then let comb logic settle.
  task automatic step(input logic av, input logic [511:0] ad, input logic al,
                      input logic bv, input logic [511:0] bd, input logic bl);
    @(posedge clk);
    #1;
    softreset       = n_rst;
    fim_if.tready   = n_fim_rdy;
    rxb_if.tready   = n_rxb_rdy;
    a_if.tvalid     = av;
    a_if.tdata      = ad;
    a_if.tlast      = al;
    b_if.tvalid     = bv;
    b_if.tdata      = bd;
    b_if.tlast      = bl;
    #1;
  endtask

  initial begin
    a_if.tkeep = '1;  a_if.tuser_vendor = 10'h0A5;
    b_if.tkeep = '1;  b_if.tuser_vendor = 10'h05A;
    n_rst = 1'b1;  n_fim_rdy = 1'b1;  n_rxb_rdy = 1'b1;

    // Reset: outputs quiet even with both sources requesting.
    step(1'b0, NONE, 1'b0, 1'b0, NONE, 1'b0);
    step(1'b1, sop(T_MWR, 10'h1, 3'd0, 11'd0, 1'b0), 1'b1, 1'b1, sop(T_MRD, 10'h2, 3'd0, 11'd0, 1'b0), 1'b1);
    check("rst_fim_tvalid", fim_if.tvalid, 1'b0);
    check("rst_a_tready",   a_if.tready,   1'b0);
    check("rst_b_tready",   b_if.tready,   1'b0);
    check("rst_rxb_tvalid", rxb_if.tvalid, 1'b0);
    n_rst = 1'b0;

    // Only A: 3-beat MWr tag 0x05 forwarded unchanged, commit one cycle after tlast.
    step(1'b1, sop(T_MWR, 10'h05, 3'd1, 11'd3, 1'b1), 1'b0, 1'b0, NONE, 1'b0);
    check("t1_b0_data",  fim_if.tdata, sop(T_MWR, 10'h05, 3'd1, 11'd3, 1'b1));
    check("t1_b0_user",  fim_if.tuser_vendor, 10'h0A5);
    check("t1_b0_ready", a_if.tready, 1'b1);
    step(1'b1, pay(1), 1'b0, 1'b0, NONE, 1'b0);
    check("t1_b1_data",  fim_if.tdata, pay(1));
    step(1'b1, pay(2), 1'b1, 1'b0, NONE, 1'b0);
    check("t1_b2_data",  fim_if.tdata, pay(2));
    check("t1_b2_last",  fim_if.tlast, 1'b1);
    check("t1_no_early_commit", rxb_if.tvalid, 1'b0);
    step(1'b0, NONE, 1'b0, 1'b0, NONE, 1'b0);
    check("t1_cpl_valid", rxb_if.tvalid, 1'b1);
    check("t1_cpl_hdr",   rxb_if.tdata, exp_cpl(10'h05, 3'd1, 11'd3, 1'b1));
    check("t1_cpl_keep",  rxb_if.tkeep, 64'h0000_0000_FFFF_FFFF);
    check("t1_cpl_last",  rxb_if.tlast, 1'b1);
    step(1'b0, NONE, 1'b0, 1'b0, NONE, 1'b0);
    check("t1_cpl_popped", rxb_if.tvalid, 1'b0);

    // Tie after reset: A (2-beat MWr) first, then B; the next tie goes to B.
    n_rst = 1'b1;
    step(1'b0, NONE, 1'b0, 1'b0, NONE, 1'b0);
    n_rst = 1'b0;
    step(1'b1, sop(T_MWR64, 10'h11, 3'd3, 11'h155, 1'b1), 1'b0, 1'b1, sop(T_MRD, 10'h21, 3'd0, 11'd0, 1'b0), 1'b1);
    check("t2_tie_a_data",  fim_if.tdata, sop(T_MWR64, 10'h11, 3'd3, 11'h155, 1'b1));
    check("t2_tie_b_ready", b_if.tready, 1'b0);
    step(1'b1, pay(7), 1'b1, 1'b1, sop(T_MRD, 10'h21, 3'd0, 11'd0, 1'b0), 1'b1);
    check("t2_a_eop_data",  fim_if.tdata, pay(7));
    check("t2_a_eop_b_rdy", b_if.tready, 1'b0);
    step(1'b1, sop(T_MRD, 10'h12, 3'd0, 11'd0, 1'b0), 1'b1, 1'b1, sop(T_MRD, 10'h21, 3'd0, 11'd0, 1'b0), 1'b1);
    check("t2_tie2_b_data",  fim_if.tdata, sop(T_MRD, 10'h21, 3'd0, 11'd0, 1'b0));
    check("t2_tie2_b_user",  fim_if.tuser_vendor, 10'h05A);
    check("t2_tie2_a_ready", a_if.tready, 1'b0);
    check("t2_cpl_hdr",      rxb_if.tdata, exp_cpl(10'h11, 3'd3, 11'h155, 1'b1));
    step(1'b1, sop(T_MRD, 10'h12, 3'd0, 11'd0, 1'b0), 1'b1, 1'b0, NONE, 1'b0);
    check("t2_a_rd_data",  fim_if.tdata, sop(T_MRD, 10'h12, 3'd0, 11'd0, 1'b0));
    check("t2_a_rd_ready", a_if.tready, 1'b1);
    check("t2_rxb_empty",  rxb_if.tvalid, 1'b0);

    // rx_b stalled: 8 writes fill the FIFO, the 9th stalls while B passes.
    n_rxb_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, sop(T_MWR, 10'(i), 3'd2, 11'd7, 1'b1), 1'b1, 1'b0, NONE, 1'b0);
      check($sformatf("t3_wr%0d_ready", i), a_if.tready, 1'b1);
    end
    step(1'b1, sop(T_MWR, 10'd8, 3'd2, 11'd7, 1'b1), 1'b1, 1'b0, NONE, 1'b0);
    check("t3_wr8_stall",  a_if.tready,   1'b0);
    check("t3_wr8_fim_tv", fim_if.tvalid, 1'b0);
    step(1'b1, sop(T_MWR, 10'd8, 3'd2, 11'd7, 1'b1), 1'b1, 1'b1, sop(T_MRD, 10'h2B, 3'd0, 11'd0, 1'b0), 1'b1);
    check("t3_b_passes",  b_if.tready,  1'b1);
    check("t3_b_data",    fim_if.tdata, sop(T_MRD, 10'h2B, 3'd0, 11'd0, 1'b0));
    check("t3_a_stalled", a_if.tready,  1'b0);
    step(1'b1, sop(T_MWR, 10'd8, 3'd2, 11'd7, 1'b1), 1'b1, 1'b0, NONE, 1'b0);
    check("t3_a_still_stalled", a_if.tready, 1'b0);
    n_rxb_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k <= 1) step(1'b1, sop(T_MWR, 10'd8, 3'd2, 11'd7, 1'b1), 1'b1, 1'b0, NONE, 1'b0);
      else        step(1'b0, NONE, 1'b0, 1'b0, NONE, 1'b0);
      check($sformatf("t3_cpl%0d_valid", k), rxb_if.tvalid, 1'b1);
      check($sformatf("t3_cpl%0d_hdr", k),   rxb_if.tdata, exp_cpl(10'(k), 3'd2, 11'd7, 1'b1));
      if (k <= 1) check($sformatf("t3_rel%0d_a_ready", k), a_if.tready, (k == 1));
    end
    step(1'b0, NONE, 1'b0, 1'b0, NONE, 1'b0);
    check("t3_drained", rxb_if.tvalid, 1'b0);

    // B 4-beat packet; A arrives mid-packet and must wait for B's tlast.
    step(1'b0, NONE, 1'b0, 1'b1, sop(T_MSG, 10'h30, 3'd0, 11'd0, 1'b0), 1'b0);
    check("t4_b0_ready", b_if.tready, 1'b1);
    for (int j = 1; j < 4; j++) begin
      step(1'b1, sop(T_MRD, 10'h33, 3'd1, 11'd0, 1'b0), 1'b0, 1'b1, pay(40 + j), (j == 3));
      check($sformatf("t4_b%0d_data", j),   fim_if.tdata, pay(40 + j));
      check($sformatf("t4_b%0d_a_rdy", j),  a_if.tready,  1'b0);
    end
    step(1'b1, sop(T_MRD, 10'h33, 3'd1, 11'd0, 1'b0), 1'b1, 1'b0, NONE, 1'b0);
    check("t4_a_after_b", a_if.tready,  1'b1);
    check("t4_a_data",    fim_if.tdata, sop(T_MRD, 10'h33, 3'd1, 11'd0, 1'b0));

    // A interrupt message: forwarded, and neither it nor the read commits.
    step(1'b1, sop(T_MSG, 10'h34, 3'd1, 11'd0, 1'b0), 1'b1, 1'b0, NONE, 1'b0);
    check("t5_msg_data",  fim_if.tdata,  sop(T_MSG, 10'h34, 3'd1, 11'd0, 1'b0));
    check("t5_rxb_none0", rxb_if.tvalid, 1'b0);
    step(1'b0, NONE, 1'b0, 1'b0, NONE, 1'b0);
    check("t5_rxb_none1", rxb_if.tvalid, 1'b0);

    // softreset on beat 2 of a 4-beat MWr with two commits pending.
    n_rxb_rdy = 1'b0;
    step(1'b1, sop(T_MWR, 10'h40, 3'd0, 11'd1, 1'b0), 1'b1, 1'b0, NONE, 1'b0);
    step(1'b1, sop(T_MWR, 10'h41, 3'd0, 11'd1, 1'b0), 1'b1, 1'b0, NONE, 1'b0);
    step(1'b1, sop(T_MWR, 10'h42, 3'd0, 11'd1, 1'b0), 1'b0, 1'b0, NONE, 1'b0);
    check("t6_pending", rxb_if.tvalid, 1'b1);
    n_rst = 1'b1;
    step(1'b1, pay(61), 1'b0, 1'b0, NONE, 1'b0);
    check("t6_rst_fim_tv", fim_if.tvalid, 1'b0);
    check("t6_rst_a_rdy",  a_if.tready,   1'b0);
    check("t6_rst_rxb_tv", rxb_if.tvalid, 1'b0);
    n_rst = 1'b0;  n_rxb_rdy = 1'b1;
    step(1'b0, NONE, 1'b0, 1'b0, NONE, 1'b0);
    check("t6_post_rxb_tv", rxb_if.tvalid, 1'b0);
    check("t6_post_fim_tv", fim_if.tvalid, 1'b0);
    step(1'b0, NONE, 1'b0, 1'b1, sop(T_MRD, 10'h50, 3'd0, 11'd0, 1'b0), 1'b1);
    check("t6_idle_b_rdy",  b_if.tready,   1'b1);
    step(1'b0, NONE, 1'b0, 1'b0, NONE, 1'b0);
    check("t6_no_commit",   rxb_if.tvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
